// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the AXI4-Lite request arbiter.
package axi_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Index width for a requester count; never narrower than one bit.
  function automatic int clog2_req(input int n);
    clog2_req = 1;
    while ((1 << clog2_req) < n) clog2_req++;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first set request at or after ptr, wrapping.
module rr_arbiter
  import axi_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  localparam int PW = clog2_req(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PW-1:0]      grant_idx
);

  logic [PW:0] pos;
  logic        found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    pos       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // ptr < NUM_REQ, so one subtraction is enough to wrap
      pos = {1'b0, ptr} + (PW+1)'(k);
      if (pos >= (PW+1)'(NUM_REQ)) pos = pos - (PW+1)'(NUM_REQ);
      if (!found && req[pos[PW-1:0]]) begin
        grant[pos[PW-1:0]] = 1'b1;
        grant_idx          = pos[PW-1:0];
        found              = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_lite_req_arbiter.sv
// Shares one AXI4-Lite master request port among NUM_REQ requesters, one
// transaction in flight, completion seen by snooping the B/R handshakes.
module axi_lite_req_arbiter
  import axi_arb_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 6,
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [1:0]                     rsp_resp,
  output logic [DATA_WIDTH-1:0]          rsp_rdata,
  output logic                           write_request,
  output logic                           read_request,
  output logic [ADDR_WIDTH-1:0]          ext_waddr,
  output logic [ADDR_WIDTH-1:0]          ext_raddr,
  output logic [DATA_WIDTH-1:0]          ext_wdata,
  input  logic                           mon_bvalid,
  input  logic                           mon_bready,
  input  logic [1:0]                     mon_bresp,
  input  logic                           mon_rvalid,
  input  logic                           mon_rready,
  input  logic [DATA_WIDTH-1:0]          mon_rdata,
  output logic                           busy,
  output logic                           timeout_flag
);

  localparam int PW = clog2_req(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 2);
  // Counter is compared before its increment, so expiry is at T-2 here
  localparam logic [CW-1:0] WD_LIMIT =
    CW'((TIMEOUT_CYCLES > 1) ? (TIMEOUT_CYCLES - 2) : 0);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] addr_arr;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] wdata_arr;

  state_t             state;
  logic [PW-1:0]      ptr, gnt_q, gnt_idx;
  logic [NUM_REQ-1:0] grant;
  logic               wr_q;
  logic [CW-1:0]      wd_cnt;
  logic               done, expire;

  assign addr_arr  = req_addr;
  assign wdata_arr = req_wdata;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (gnt_idx)
  );

  assign req_ready = (state == IDLE && !ARESET) ? grant : '0;
  assign busy      = (state != IDLE);
  assign done      = wr_q ? (mon_bvalid & mon_bready) : (mon_rvalid & mon_rready);
  assign expire    = (TIMEOUT_CYCLES != 0) && (wd_cnt >= WD_LIMIT);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state         <= IDLE;
      ptr           <= '0;
      gnt_q         <= '0;
      wr_q          <= 1'b0;
      wd_cnt        <= '0;
      rsp_valid     <= '0;
      rsp_resp      <= '0;
      rsp_rdata     <= '0;
      write_request <= 1'b0;
      read_request  <= 1'b0;
      ext_waddr     <= '0;
      ext_raddr     <= '0;
      ext_wdata     <= '0;
      timeout_flag  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|grant) begin
            gnt_q <= gnt_idx;
            wr_q  <= req_write[gnt_idx];
            if (req_write[gnt_idx]) begin
              write_request <= 1'b1;
              ext_waddr     <= addr_arr[gnt_idx];
              ext_wdata     <= wdata_arr[gnt_idx];
            end else begin
              read_request  <= 1'b1;
              ext_raddr     <= addr_arr[gnt_idx];
            end
            state <= ISSUE;
          end
        end
        ISSUE: begin
          write_request <= 1'b0;
          read_request  <= 1'b0;
          wd_cnt        <= '0;
          state         <= WAIT;
        end
        WAIT: begin
          // A real completion wins over a watchdog expiry in the same cycle
          if (done || expire) begin
            rsp_valid <= ONE << gnt_q;
            if (done) begin
              rsp_resp  <= wr_q ? mon_bresp : RESP_OKAY;
              rsp_rdata <= wr_q ? '0 : mon_rdata;
            end else begin
              rsp_resp     <= RESP_DECERR;
              rsp_rdata    <= '0;
              timeout_flag <= 1'b1;
            end
            ext_waddr <= '0;
            ext_raddr <= '0;
            ext_wdata <= '0;
            state     <= RESP;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        RESP: begin
          rsp_valid <= '0;
          rsp_resp  <= '0;
          rsp_rdata <= '0;
          ptr       <= (gnt_q == PW'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_req_arbiter.sv
// Directed bench for axi_lite_req_arbiter with a short watchdog (8 cycles).
module tb_axi_lite_req_arbiter;

  localparam int DW = 32;
  localparam int AW = 6;
  localparam int NR = 2;
  localparam int TO = 8;

  logic              ACLK, ARESET;
  logic [NR-1:0]     req_valid, req_write, req_ready, rsp_valid;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic [1:0]        rsp_resp, mon_bresp;
  logic [DW-1:0]     rsp_rdata, ext_wdata, mon_rdata;
  logic              write_request, read_request, busy, timeout_flag;
  logic [AW-1:0]     ext_waddr, ext_raddr;
  logic              mon_bvalid, mon_bready, mon_rvalid, mon_rready;
  logic [85:0]       all_out;

  int n_tests = 0;
  int n_fail  = 0;

  axi_lite_req_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR), .TIMEOUT_CYCLES(TO)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_resp(rsp_resp), .rsp_rdata(rsp_rdata),
    .write_request(write_request), .read_request(read_request),
    .ext_waddr(ext_waddr), .ext_raddr(ext_raddr), .ext_wdata(ext_wdata),
    .mon_bvalid(mon_bvalid), .mon_bready(mon_bready), .mon_bresp(mon_bresp),
    .mon_rvalid(mon_rvalid), .mon_rready(mon_rready), .mon_rdata(mon_rdata),
    .busy(busy), .timeout_flag(timeout_flag)
  );

  assign all_out = {req_ready, rsp_valid, rsp_resp, rsp_rdata, write_request,
                    read_request, ext_waddr, ext_raddr, ext_wdata, busy, timeout_flag};

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge ACLK);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]          = v;
    req_write[i]          = w;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic mon_clear;
    mon_bvalid = 1'b0; mon_bready = 1'b0; mon_bresp = 2'b00;
    mon_rvalid = 1'b0; mon_rready = 1'b0; mon_rdata = '0;
  endtask

  task automatic test_reset;
    ARESET = 1'b1;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    mon_clear();
    tick(); tick();
    ARESET = 1'b0;
    #1;
    n_tests++;
    if (all_out !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected 0", all_out);
    end
  endtask

  task automatic test_single_write;
    set_req(0, 1'b1, 1'b1, 6'h04, 32'hDEADBEEF); #1;
    n_tests++;
    if (req_ready !== 2'b01) begin
      n_fail++; $display("FAIL sw_accept: got %b expected 01", req_ready);
    end
    tick(); req_valid[0] = 1'b0; #1;
    n_tests++;
    if ({write_request, read_request, busy} !== 3'b101) begin
      n_fail++; $display("FAIL sw_issue_pulse: got %b expected 101", {write_request, read_request, busy});
    end
    n_tests++;
    if ({ext_waddr, ext_wdata, ext_raddr} !== {6'h04, 32'hDEADBEEF, 6'h00}) begin
      n_fail++; $display("FAIL sw_ext: got %h/%h/%h expected 04/deadbeef/00", ext_waddr, ext_wdata, ext_raddr);
    end
    tick();
    mon_bvalid = 1'b1; mon_bready = 1'b1; mon_bresp = 2'b00;
    n_tests++;
    if ({write_request, ext_waddr, ext_wdata} !== {1'b0, 6'h04, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL sw_wait_hold: got %b/%h/%h expected 0/04/deadbeef", write_request, ext_waddr, ext_wdata);
    end
    tick(); mon_clear();
    n_tests++;
    if ({rsp_valid, rsp_resp, rsp_rdata} !== {2'b01, 2'b00, 32'h0}) begin
      n_fail++; $display("FAIL sw_rsp: got %b/%b/%h expected 01/00/0", rsp_valid, rsp_resp, rsp_rdata);
    end
    tick();
    n_tests++;
    if ({rsp_valid, busy} !== 3'b000) begin
      n_fail++; $display("FAIL sw_idle: got %b expected 000", {rsp_valid, busy});
    end
  endtask

  task automatic test_read_back;
    set_req(1, 1'b1, 1'b0, 6'h04, 32'h0); #1;
    n_tests++;
    if (req_ready !== 2'b10) begin
      n_fail++; $display("FAIL rb_accept: got %b expected 10", req_ready);
    end
    tick(); req_valid[1] = 1'b0; #1;
    n_tests++;
    if ({write_request, read_request, ext_raddr, ext_waddr, ext_wdata} !== {2'b01, 6'h04, 6'h00, 32'h0}) begin
      n_fail++; $display("FAIL rb_issue: got %b%b/%h/%h/%h expected 01/04/00/0",
                         write_request, read_request, ext_raddr, ext_waddr, ext_wdata);
    end
    tick(); tick();
    n_tests++;
    if ({rsp_valid, busy, ext_raddr} !== {2'b00, 1'b1, 6'h04}) begin
      n_fail++; $display("FAIL rb_wait: got %b/%b/%h expected 00/1/04", rsp_valid, busy, ext_raddr);
    end
    tick();
    mon_rvalid = 1'b1; mon_rready = 1'b1; mon_rdata = 32'hDEADBEEF;
    tick(); mon_clear();
    n_tests++;
    if ({rsp_valid, rsp_resp, rsp_rdata} !== {2'b10, 2'b00, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL rb_rsp: got %b/%b/%h expected 10/00/deadbeef", rsp_valid, rsp_resp, rsp_rdata);
    end
    tick();
  endtask

  task automatic test_round_robin;
    logic [1:0]    exp_g;
    logic [AW-1:0] exp_a;
    set_req(0, 1'b1, 1'b1, 6'h10, 32'hA0);
    set_req(1, 1'b1, 1'b1, 6'h11, 32'hA1);
    for (int t = 0; t < 4; t++) begin
      exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
      exp_a = (t % 2 == 0) ? 6'h10 : 6'h11;
      #1;
      n_tests++;
      if (req_ready !== exp_g) begin
        n_fail++; $display("FAIL rr_grant_%0d: got %b expected %b", t, req_ready, exp_g);
      end
      tick();
      n_tests++;
      if ({write_request, ext_waddr} !== {1'b1, exp_a}) begin
        n_fail++; $display("FAIL rr_addr_%0d: got %b/%h expected 1/%h", t, write_request, ext_waddr, exp_a);
      end
      tick();
      mon_bvalid = 1'b1; mon_bready = 1'b1; mon_bresp = 2'b00;
      tick(); mon_clear();
      n_tests++;
      if (rsp_valid !== exp_g) begin
        n_fail++; $display("FAIL rr_rsp_%0d: got %b expected %b", t, rsp_valid, exp_g);
      end
      if (t == 3) req_valid = '0;
      tick();
    end
    #1;
    n_tests++;
    if ({req_ready, busy} !== 3'b000) begin
      n_fail++; $display("FAIL rr_done_idle: got %b expected 000", {req_ready, busy});
    end
  endtask

  task automatic test_stray_and_simul;
    set_req(0, 1'b1, 1'b1, 6'h08, 32'h0BADF00D); #1;
    n_tests++;
    if (req_ready !== 2'b01) begin
      n_fail++; $display("FAIL st_accept: got %b expected 01", req_ready);
    end
    tick(); req_valid[0] = 1'b0;
    mon_bvalid = 1'b1; mon_bready = 1'b1; mon_bresp = 2'b11;
    tick(); mon_clear();
    mon_rvalid = 1'b1; mon_rready = 1'b1; mon_rdata = 32'h55;
    tick(); mon_clear();
    n_tests++;
    if ({rsp_valid, busy} !== 3'b001) begin
      n_fail++; $display("FAIL st_stray_ignored: got %b expected 001", {rsp_valid, busy});
    end
    repeat (4) tick();
    n_tests++;
    if (rsp_valid !== 2'b00) begin
      n_fail++; $display("FAIL st_no_early: got %b expected 00", rsp_valid);
    end
    tick();
    mon_bvalid = 1'b1; mon_bready = 1'b1; mon_bresp = 2'b10;
    tick(); mon_clear();
    n_tests++;
    if ({rsp_valid, rsp_resp, rsp_rdata, timeout_flag} !== {2'b01, 2'b10, 32'h0, 1'b0}) begin
      n_fail++; $display("FAIL st_expiry_completion: got %b/%b/%h/%b expected 01/10/0/0",
                         rsp_valid, rsp_resp, rsp_rdata, timeout_flag);
    end
    tick();
  endtask

  task automatic test_watchdog;
    set_req(1, 1'b1, 1'b1, 6'h0C, 32'h77); #1;
    n_tests++;
    if (req_ready !== 2'b10) begin
      n_fail++; $display("FAIL wd_accept: got %b expected 10", req_ready);
    end
    tick(); req_valid[1] = 1'b0;
    repeat (7) tick();
    n_tests++;
    if ({rsp_valid, timeout_flag, busy} !== 4'b0001) begin
      n_fail++; $display("FAIL wd_not_yet: got %b expected 0001", {rsp_valid, timeout_flag, busy});
    end
    tick();
    n_tests++;
    if ({rsp_valid, rsp_resp, rsp_rdata, timeout_flag} !== {2'b10, 2'b11, 32'h0, 1'b1}) begin
      n_fail++; $display("FAIL wd_expire: got %b/%b/%h/%b expected 10/11/0/1",
                         rsp_valid, rsp_resp, rsp_rdata, timeout_flag);
    end
    tick();
    set_req(0, 1'b1, 1'b0, 6'h04, 32'h0); #1;
    n_tests++;
    if (req_ready !== 2'b01) begin
      n_fail++; $display("FAIL wd_next_accept: got %b expected 01", req_ready);
    end
    tick(); req_valid[0] = 1'b0;
    tick();
    mon_rvalid = 1'b1; mon_rready = 1'b1; mon_rdata = 32'h12345678;
    tick(); mon_clear();
    n_tests++;
    if ({rsp_valid, rsp_resp, rsp_rdata, timeout_flag} !== {2'b01, 2'b00, 32'h12345678, 1'b1}) begin
      n_fail++; $display("FAIL wd_next_rsp: got %b/%b/%h/%b expected 01/00/12345678/1",
                         rsp_valid, rsp_resp, rsp_rdata, timeout_flag);
    end
    tick();
  endtask

  task automatic test_reset_mid_wait;
    // pointer is 1 here, so a lone request from 0 exercises the wrap
    set_req(0, 1'b1, 1'b1, 6'h20, 32'h1); #1;
    n_tests++;
    if (req_ready !== 2'b01) begin
      n_fail++; $display("FAIL mr_wrap_accept: got %b expected 01", req_ready);
    end
    tick(); req_valid[0] = 1'b0;
    tick();
    ARESET = 1'b1;
    tick();
    ARESET = 1'b0;
    mon_bvalid = 1'b1; mon_bready = 1'b1; mon_bresp = 2'b00;
    n_tests++;
    if (all_out !== '0) begin
      n_fail++; $display("FAIL mr_outputs: got %h expected 0", all_out);
    end
    tick(); mon_clear();
    n_tests++;
    if ({rsp_valid, busy} !== 3'b000) begin
      n_fail++; $display("FAIL mr_no_rsp: got %b expected 000", {rsp_valid, busy});
    end
    set_req(0, 1'b1, 1'b1, 6'h00, 32'h0);
    set_req(1, 1'b1, 1'b1, 6'h00, 32'h0); #1;
    n_tests++;
    if (req_ready !== 2'b01) begin
      n_fail++; $display("FAIL mr_ptr_zero: got %b expected 01", req_ready);
    end
    tick(); req_valid = '0;
    tick();
    mon_bvalid = 1'b1; mon_bready = 1'b1;
    tick(); mon_clear();
    tick();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_back();
    test_round_robin();
    test_stray_and_simul();
    test_watchdog();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_lite_req_arbiter.md
Name: axi_lite_req_arbiter

Overview:
Shares the single external request port of the AXI4-Lite master (write_request/read_request, ext_waddr/ext_raddr/ext_wdata) among NUM_REQ independent requesters using round-robin arbitration. Only one transaction is outstanding at a time. Completion is detected by monitoring the B and R channel handshakes on the AXI interconnect. Each requester receives a response pulse carrying the response code and read data. A watchdog terminates transactions that hang.

Parameters:
DATA_WIDTH, 32, data width; matches the master and slave.
ADDR_WIDTH, 6, address width; matches the master and slave.
NUM_REQ, 2, number of requesters; legal range 2..8.
TIMEOUT_CYCLES, 256, WAIT-state cycle limit before a forced error completion; 0 disables the watchdog.

Ports:
ACLK  in  1  clock; all logic on the rising edge.
ARESET  in  1  synchronous, active-high reset.
req_valid  in  NUM_REQ  per-requester request pending; held until accepted.
req_write  in  NUM_REQ  1 = write, 0 = read.
req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i occupies slice i.
req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data.
req_ready  out  NUM_REQ  one-hot, one-cycle accept pulse.
rsp_valid  out  NUM_REQ  one-hot, one-cycle completion pulse.
rsp_resp  out  2  response code; valid while rsp_valid is nonzero.
rsp_rdata  out  DATA_WIDTH  read data; 0 for writes; valid while rsp_valid is nonzero.
write_request  out  1  one-cycle pulse to the master.
read_request  out  1  one-cycle pulse to the master.
ext_waddr  out  ADDR_WIDTH  write address to the master.
ext_raddr  out  ADDR_WIDTH  read address to the master.
ext_wdata  out  DATA_WIDTH  write data to the master.
mon_bvalid, mon_bready  in  1 each  monitored write-response handshake.
mon_bresp  in  2  monitored BRESP.
mon_rvalid, mon_rready  in  1 each  monitored read-data handshake.
mon_rdata  in  DATA_WIDTH  monitored RDATA.
busy  out  1  high in every state except IDLE.
timeout_flag  out  1  sticky; set on any watchdog expiry; cleared only by reset.

Behaviour:
- Reset: every output is 0, state = IDLE, round-robin pointer = 0, watchdog counter = 0. Reset takes effect in any state, including mid-transaction. The responses of an aborted transaction are never delivered.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid bit is set, grant the first set bit at or after the pointer, wrapping modulo NUM_REQ.
  - In the same cycle: pulse req_ready[g]; latch g, req_write, addr and wdata; go to ISSUE.
  - If no bit is set, stay in IDLE.
- ISSUE (1 cycle):
  - Pulse write_request or read_request according to the latched direction.
  - Drive ext_waddr/ext_wdata for a write, or ext_raddr for a read, from the latches.
  - Clear the watchdog counter; go to WAIT.
- ext_* outputs: held constant from ISSUE until the end of WAIT; unused ext_* outputs are 0.
- WAIT:
  - A write completes on mon_bvalid&mon_bready: capture mon_bresp, set rdata = 0.
  - A read completes on mon_rvalid&mon_rready: capture mon_rdata and set resp = 2'b00 (the R channel carries no RRESP).
  - On completion go to RESP.
  - A handshake of the wrong type is ignored. All handshakes are ignored outside WAIT.
  - The watchdog counter increments each WAIT cycle. If the counter reaches TIMEOUT_CYCLES-1 with no completion: resp = 2'b11, rdata = 0, set timeout_flag, go to RESP.
  - A completion arriving on the expiry cycle takes priority over the timeout.
- RESP (1 cycle): pulse rsp_valid[g] with rsp_resp and rsp_rdata; set pointer = (g+1) mod NUM_REQ; go to IDLE.
- Latency:
  - Accept at cycle A; request pulse at A+1; completion handshake at cycle C ≥ A+2; rsp_valid at C+1.
  - The next accept is possible at C+2. The minimum cycle-to-cycle repeat period is 4 cycles.
- A requester may drop req_valid before it is accepted; no accept pulse is then generated for it. A requester may reassert req_valid in its own RESP cycle; it is serviced subject to the pointer.
- Fairness: a continuously requesting port waits at most NUM_REQ-1 transactions.

Decomposition:
- Package axi_arb_pkg:
  - state enum {IDLE, ISSUE, WAIT, RESP};
  - response constants RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11;
  - function clog2_req.
- Sub-module rr_arbiter (NUM_REQ): combinational one-hot grant computed from the request vector and the pointer. The top module owns the pointer register and updates it in RESP.

Test Plan:
- Single write: requester 0 writes addr 0x04, data 0xDEADBEEF; slave returns BRESP 00 → req_ready[0] in cycle 0; write_request in cycle 1 with ext_waddr = 0x04 and ext_wdata = 0xDEADBEEF; rsp_valid = 2'b01, rsp_resp = 00, rsp_rdata = 0.
- Read-back: requester 1 reads addr 0x04 → read_request with ext_raddr = 0x04; rsp_valid = 2'b10, rsp_rdata = 0xDEADBEEF, rsp_resp = 00.
- Round-robin: both requesters hold req_valid for 4 transactions from reset → grant order 0, 1, 0, 1; no requester starves.
- Watchdog: TIMEOUT_CYCLES = 8 with the B channel held off → rsp_resp = 11 exactly 8 cycles after the request pulse, timeout_flag = 1; the next transaction then completes normally with timeout_flag still 1.
- Stray and simultaneous handshakes: an R handshake during a write WAIT is ignored; a completion on the expiry cycle gives resp = BRESP and timeout_flag stays 0.
- Reset mid-WAIT: assert ARESET for 1 cycle → all outputs 0 the next cycle; no rsp_valid for the aborted transaction; the pointer returns to 0.
